uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
Receive-side counterpart of the UART TX path. Oversamples the serial line RX_IN at Prescale clocks per bit, then:
- detects and qualifies the start bit;
- majority-samples each bit and deserializes the data bits LSB first;
- optionally checks parity, then checks the stop bit;
- presents the parallel word with a one-cycle valid pulse.
Sits between the RX pin (or CDC synchronizer) and the system controller, in the UART clock domain.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_WIDTH, 6, width of Prescale input; supported oversampling values are even, 8..2^PRESCALE_WIDTH-2

Ports:
CLK  input  1  UART oversampling clock
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high
Prescale  input  PRESCALE_WIDTH  clocks per bit (8, 16 or 32 in system use)
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even, 1 = odd parity
P_DATA  output  DATA_WIDTH  received word, held until next valid frame
Data_Valid  output  1  one-cycle pulse, P_DATA updated and frame error-free
Par_Err  output  1  one-cycle pulse, parity mismatch
Stp_Err  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Reset (async, RST=0): state IDLE, counters 0, P_DATA=0, Data_Valid=0, Par_Err=0, Stp_Err=0. Reset mid-frame aborts the frame with no pulses.
- Edge counter runs 0..Prescale-1 per bit. Bit counter counts data bits 0..DATA_WIDTH-1.
- Sampling: RX_IN captured at edge counts P/2-1, P/2, P/2+1; bit value = majority of the 3 samples, valid from edge P/2+2.
- Config (Prescale, PAR_EN, PAR_TYP) latched when leaving IDLE. Changes mid-frame are ignored.
- FSM:
  - IDLE: RX_IN=0 -> START, edge counter=0 (this cycle counts as edge 0).
  - START: if sampled bit=1 (glitch) -> IDLE at edge P/2+2, no pulses. Otherwise at edge P-1 -> DATA.
  - DATA: shift sampled bit in at MSB, shift right (LSB first). After bit DATA_WIDTH-1 at edge P-1 -> PARITY if PAR_EN, else STOP.
  - PARITY: expected bit = XOR(data) ^ PAR_TYP. Mismatch latched internally. At edge P-1 -> STOP.
  - STOP: at edge P-1, evaluate the frame and raise exactly one of:
    - Stp_Err if stop sample=0;
    - else Par_Err if parity mismatch;
    - else Data_Valid, with P_DATA loaded from the shift register the same cycle.
  - STOP exit: if RX_IN=0 in that cycle -> START with edge counter=0 (back-to-back frames, no lost cycle); else -> IDLE.
- Latency: Data_Valid rises (2+DATA_WIDTH+PAR_EN)*Prescale - 1 cycles after the first cycle RX_IN is seen low in IDLE.
- On error frames, P_DATA keeps its previous value.
- Pulses are never simultaneous; each lasts exactly 1 cycle.

Optional Feature:
UART_RX_IN_SYNC_EN:
- Defined: RX_IN passes through a 2-flop synchronizer (reset to 1) before the FSM. All latencies grow by 2 cycles.
- Undefined: RX_IN is used directly; the integrator guarantees it is already synchronous.

Decomposition:
- Package uart_rx_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP), majority-vote function, sample-offset constants (-1, 0, +1 around P/2).
- One natural sub-module, uart_rx_sampler: edge counter, 3-tap capture, majority output, and a "sample_ready" / "bit_end" strobe to the FSM.
- Deserialize and parity logic stay in the top.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> P_DATA=0xA5, Data_Valid 1 cycle, 87 cycles after start low; no errors.
- Same frame with parity bit 1 -> Par_Err 1 cycle, Data_Valid=0, P_DATA unchanged.
- Prescale=16, PAR_EN=0, 0x3C with stop=0 -> Stp_Err 1 cycle at cycle 159, no Data_Valid.
- RX_IN low for 3 cycles only (Prescale=8) -> FSM returns to IDLE, no pulses; next valid frame 0x5A received correctly.
- Prescale=32, two back-to-back frames 0x01, 0xFF (no idle gap) -> two Data_Valid pulses exactly 320 cycles apart, correct data; single-sample glitch inside a bit does not corrupt data.
- RST asserted mid-DATA -> outputs 0 immediately; after release, next frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: FSM state type, sample-offset constants and the majority vote
// shared by the UART receive core and its bit sampler.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Sample taps relative to the bit centre (Prescale/2).
    localparam int SAMPLE_OFS_EARLY = -1;
    localparam int SAMPLE_OFS_MID   = 0;
    localparam int SAMPLE_OFS_LATE  = 1;
    // The voted bit is usable one edge after the late tap has been captured.
    localparam int READY_OFS        = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter, three-tap capture around the bit
// centre, majority output and the timing strobes used by the receive FSM.
module uart_rx_sampler #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      rx,
    input  logic                      active,
    input  logic                      restart,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_val,
    output logic                      sample_ready,
    output logic                      eval_strobe,
    output logic                      bit_end
);

    import uart_rx_pkg::*;

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q;
    logic [PRESCALE_WIDTH-1:0] half;
    logic [PRESCALE_WIDTH-1:0] tap_early;
    logic [PRESCALE_WIDTH-1:0] tap_mid;
    logic [PRESCALE_WIDTH-1:0] tap_late;
    logic [PRESCALE_WIDTH-1:0] ready_edge;
    logic [PRESCALE_WIDTH-1:0] eval_edge;
    logic [PRESCALE_WIDTH-1:0] last_edge;
    logic [2:0]                taps_q;

    assign half       = prescale >> 1;
    assign tap_early  = half + PRESCALE_WIDTH'(SAMPLE_OFS_EARLY);
    assign tap_mid    = half + PRESCALE_WIDTH'(SAMPLE_OFS_MID);
    assign tap_late   = half + PRESCALE_WIDTH'(SAMPLE_OFS_LATE);
    assign ready_edge = half + PRESCALE_WIDTH'(READY_OFS);
    assign eval_edge  = prescale - PRESCALE_WIDTH'(2);
    assign last_edge  = prescale - PRESCALE_WIDTH'(1);

    // Edge counter: the restart cycle is edge 0, so the register restarts at 1.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (!RST) begin
            edge_cnt_q <= '0;
        end else if (restart) begin
            edge_cnt_q <= PRESCALE_WIDTH'(1);
        end else if (!active || edge_cnt_q == last_edge) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    // Capture the line at the three taps around the bit centre.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            taps_q <= 3'b111;
        end else if (active) begin
            if (edge_cnt_q == tap_early) taps_q[0] <= rx;
            if (edge_cnt_q == tap_mid)   taps_q[1] <= rx;
            if (edge_cnt_q == tap_late)  taps_q[2] <= rx;
        end
    end

    assign bit_val      = majority3(taps_q[0], taps_q[1], taps_q[2]);
    assign sample_ready = active && (edge_cnt_q == ready_edge);
    assign eval_strobe  = active && (edge_cnt_q == eval_edge);
    assign bit_end      = active && (edge_cnt_q == last_edge);

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver. Qualifies the start bit,
// deserializes DATA_WIDTH bits LSB first, optionally checks parity, checks
// the stop bit and reports the frame with exactly one one-cycle pulse.
// Outputs are registered one edge early so they are visible during the last
// oversampling cycle of the stop bit, with P_DATA already updated.
// Build option: define UART_RX_IN_SYNC_EN to insert a 2-flop synchronizer on
// RX_IN (adds 2 cycles to every latency).
module uart_rx_core #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      Par_Err,
    output logic                      Stp_Err
);

    import uart_rx_pkg::*;

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e                 state_q, state_d;
    logic                      rx_s;
    logic                      start_frame;
    logic                      active;
    logic                      bit_val;
    logic                      sample_ready;
    logic                      eval_strobe;
    logic                      bit_end;
    logic                      last_bit;
    logic [PRESCALE_WIDTH-1:0] cfg_prescale;
    logic                      cfg_par_en;
    logic                      cfg_par_typ;
    logic [BIT_CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic                      par_mis_q;

`ifdef UART_RX_IN_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer, reset to the idle line level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], RX_IN};
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    assign active   = (state_q != IDLE);
    assign last_bit = (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1));

    uart_rx_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .rx          (rx_s),
        .active      (active),
        .restart     (start_frame),
        .prescale    (cfg_prescale),
        .bit_val     (bit_val),
        .sample_ready(sample_ready),
        .eval_strobe (eval_strobe),
        .bit_end     (bit_end)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; a low line in IDLE or at the end of STOP opens a frame.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d     = state_q;
        start_frame = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d     = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (sample_ready && bit_val) state_d = IDLE;
                else if (bit_end)            state_d = DATA;
            end
            DATA: begin
                if (bit_end && last_bit) state_d = cfg_par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (!rx_s) begin
                        state_d     = START;
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Config latch, deserializer, bit counter and parity mismatch flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cfg_prescale <= '0;
            cfg_par_en   <= 1'b0;
            cfg_par_typ  <= 1'b0;
            bit_cnt_q    <= '0;
            // NOTE: the shift register is small enough to reset; it keeps P_DATA loads defined.
            shift_q      <= '0;
            par_mis_q    <= 1'b0;
        end else begin
            if (start_frame) begin
                cfg_prescale <= Prescale;
                cfg_par_en   <= PAR_EN;
                cfg_par_typ  <= PAR_TYP;
                bit_cnt_q    <= '0;
                par_mis_q    <= 1'b0;
            end
            if (state_q == DATA && sample_ready) begin
                shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
            end
            if (state_q == DATA && bit_end) begin
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + BIT_CNT_W'(1);
            end
            if (state_q == PARITY && sample_ready) begin
                par_mis_q <= ((^shift_q) ^ cfg_par_typ) != bit_val;
            end
        end
    end

    // Frame verdict: one pulse, stop error over parity error over valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            if (state_q == STOP && eval_strobe) begin
                if (!bit_val) begin
                    Stp_Err <= 1'b1;
                end else if (par_mis_q) begin
                    Par_Err <= 1'b1;
                end else begin
                    Data_Valid <= 1'b1;
                    P_DATA     <= shift_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table-driven frames plus hand-written corner sequences;
// every expected pulse (kind, data, cycle) is queued when its frame is driven
// and checked when the receiver pulses.
module tb_uart_rx_core;

`ifdef UART_RX_IN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_PAR   = 3'b010;
    localparam logic [2:0] K_STP   = 3'b100;

    typedef struct {
        logic [5:0] prescale;
        logic       par_en;
        logic       par_typ;
        logic       par_flip;
        logic       stop_bit;
        logic [7:0] data;
        int         glitch_bit;
        int         gap;
        logic       scramble;
    } vec_t;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cycle;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   n_pulses = 0;
    int   prev_valid_cyc = 0;
    int   last_valid_cyc = 0;
    logic [7:0] last_good = 8'h00;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[8];

    uart_rx_core dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .Prescale  (Prescale),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .Par_Err   (Par_Err),
        .Stp_Err   (Stp_Err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic handle_pulse();
        logic [2:0] kind;
        kind = {Stp_Err, Par_Err, Data_Valid};
        n_pulses++;
        if (exp_q.size() == 0) begin
            check($sformatf("unexpected_pulse@%0d", cyc), {29'd0, kind}, 32'd0);
        end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("pulse%0d_kind", n_pulses), {29'd0, kind}, {29'd0, mon_e.kind});
            check($sformatf("pulse%0d_cycle", n_pulses), cyc, mon_e.cycle);
            check($sformatf("pulse%0d_pdata", n_pulses), {24'd0, P_DATA}, {24'd0, mon_e.data});
        end
        if (Data_Valid) begin
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
        end
    endtask

    always @(negedge CLK) begin
        if (RST && (Data_Valid || Par_Err || Stp_Err)) handle_pulse();
    end

    // Drive one bit for p cycles; optionally invert a single oversample.
    task automatic drive_bit(input logic v, input int p, input int glitch_idx);
        for (int i = 0; i < p; i++) begin
            RX_IN = (i == glitch_idx) ? ~v : v;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input vec_t v);
        exp_t e;
        logic par_bit;
        int   p;
        int   n_bits;
        p       = int'(v.prescale);
        par_bit = (^v.data) ^ v.par_typ ^ v.par_flip;
        n_bits  = 2 + 8 + (v.par_en ? 1 : 0);
        Prescale = v.prescale;
        PAR_EN   = v.par_en;
        PAR_TYP  = v.par_typ;
        e.cycle = cyc + n_bits * p - 1 + SYNC_LAT;
        if (!v.stop_bit) begin
            e.kind = K_STP;
        end else if (v.par_en && v.par_flip) begin
            e.kind = K_PAR;
        end else begin
            e.kind    = K_VALID;
            last_good = v.data;
        end
        e.data = last_good;
        exp_q.push_back(e);
        drive_bit(1'b0, p, -1);
        if (v.scramble) begin
            Prescale = (v.prescale == 6'd8) ? 6'd16 : 6'd8;
            PAR_EN   = ~v.par_en;
            PAR_TYP  = ~v.par_typ;
        end
        for (int i = 0; i < 8; i++) begin
            drive_bit(v.data[i], p, (i == v.glitch_bit) ? p / 2 : -1);
        end
        if (v.par_en) drive_bit(par_bit, p, -1);
        drive_bit(v.stop_bit, p, -1);
        drive_bit(1'b1, v.gap, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    initial begin
        int pulses_before;
        vec_t v;

        // prescale, par_en, par_typ, par_flip, stop_bit, data, glitch_bit, gap, scramble
        vecs[0] = '{6'd8,  1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, -1, 40, 1'b0};
        vecs[1] = '{6'd8,  1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, -1, 40, 1'b0};
        vecs[2] = '{6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, -1, 40, 1'b0};
        vecs[3] = '{6'd16, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, -1, 40, 1'b1};
        vecs[4] = '{6'd8,  1'b1, 1'b1, 1'b1, 1'b1, 8'h7E, -1, 40, 1'b0};
        vecs[5] = '{6'd16, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, -1, 40, 1'b0};
        vecs[6] = '{6'd62, 1'b0, 1'b0, 1'b0, 1'b1, 8'h96, -1, 40, 1'b1};
        vecs[7] = '{6'd10, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0F,  2, 40, 1'b0};

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        check("reset_pdata", {24'd0, P_DATA}, 32'd0);
        check("reset_valid", {31'd0, Data_Valid}, 32'd0);
        check("reset_par_err", {31'd0, Par_Err}, 32'd0);
        check("reset_stp_err", {31'd0, Stp_Err}, 32'd0);
        RST = 1'b1;
        drive_bit(1'b1, 5, -1);

        // Table-driven frames.
        for (int i = 0; i < 8; i++) send_frame(vecs[i]);

        // Start-bit glitch: line low for 3 cycles only, then a good frame.
        pulses_before = n_pulses;
        drive_bit(1'b0, 3, -1);
        drive_bit(1'b1, 40, -1);
        check("glitch_no_pulse", n_pulses, pulses_before);
        v = '{6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, -1, 20, 1'b0};
        send_frame(v);

        // Mid-DATA reset aborts the frame and clears outputs at once.
        check("pdata_before_reset", {24'd0, P_DATA}, 32'h5A);
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 8, -1);
        drive_bit(1'b1, 8, -1);
        drive_bit(1'b0, 8, -1);
        drive_bit(1'b1, 4, -1);
        RST = 1'b0;
        #1;
        check("midreset_pdata", {24'd0, P_DATA}, 32'd0);
        check("midreset_valid", {29'd0, Stp_Err, Par_Err, Data_Valid}, 32'd0);
        RX_IN = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        last_good = 8'h00;
        drive_bit(1'b1, 5, -1);
        v = '{6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, -1, 20, 1'b0};
        send_frame(v);

        // Back-to-back frames at Prescale=32, glitch at the centre of bit 3.
        v = '{6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, -1, 0, 1'b0};
        send_frame(v);
        v = '{6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 3, 40, 1'b0};
        send_frame(v);
        check("back_to_back_spacing", last_valid_cyc - prev_valid_cyc, 32'd320);

        // Drain the scoreboard within a bounded time.
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge CLK);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("total_pulses", n_pulses, 32'd12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
